// File: rtl/parking_lane_arbiter.sv
// ============================================================================
// parking_lane_arbiter
//
// Controller for a single-lane parking ramp that is shared by entering and
// exiting cars. It arbitrates entry/exit requests (round-robin when both are
// eligible) and sequences password authorisation for entry through an
// external checker. It also tracks occupancy against CAPACITY and drives the
// green/red lane LEDs.
//
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   asynchronous active-low reset
//   ent_req     in   entry front sensor (level): car waiting at entry
//   ext_req     in   exit sensor (level): car waiting to leave
//   pw_ok       in   one-cycle pulse: password accepted
//   pw_bad      in   one-cycle pulse: password rejected
//   lane_busy   in   lane back sensor (level): car physically in lane
//   ent_grant   out  entry barrier open
//   ext_grant   out  exit barrier open
//   gLED        out  green: a grant is active
//   rLED        out  red: no grant active
//   car_count   out  cars currently parked (saturates at 0 and CAPACITY)
//   full        out  car_count == CAPACITY
//   lockout     out  entry locked after MAX_TRIES consecutive failures
//
// Optional feature, macro PARK_STATS_EN:
//   tot_entries out  completed entries, saturating 16-bit counter
//   tot_rejects out  pw_bad pulses seen while authorising, saturating
//
// All outputs are registered and change on the same edge as the state
// transition that causes them.
// ============================================================================
module parking_lane_arbiter #(
    parameter int CAPACITY    = 4,
    parameter int CNT_W       = 4,
    parameter int TIMEOUT     = 8,
    parameter int MAX_TRIES   = 3,
    parameter int LOCK_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ent_req,
    input  logic             ext_req,
    input  logic             pw_ok,
    input  logic             pw_bad,
    input  logic             lane_busy,
    output logic             ent_grant,
    output logic             ext_grant,
    output logic             gLED,
    output logic             rLED,
    output logic [CNT_W-1:0] car_count,
    output logic             full,
    output logic             lockout
`ifdef PARK_STATS_EN
    ,
    output logic [15:0]      tot_entries,
    output logic [15:0]      tot_rejects
`endif
);

    // One timer is shared by AUTH, the pass states and LOCK, so it must be
    // wide enough for the longest of the two intervals.
    localparam int TMR_MAX = (TIMEOUT > LOCK_CYCLES) ? TIMEOUT : LOCK_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int TRY_W   = $clog2(MAX_TRIES + 1);

    localparam logic [TMR_W-1:0] TMO_LAST  = TMR_W'(TIMEOUT - 1);
    localparam logic [TMR_W-1:0] LOCK_LAST = TMR_W'(LOCK_CYCLES - 1);
    localparam logic [TRY_W-1:0] TRY_MAX   = TRY_W'(MAX_TRIES);
    localparam logic [CNT_W-1:0] CAP_C     = CNT_W'(CAPACITY);
    localparam logic [CNT_W-1:0] CNT_ZERO  = '0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AUTH,
        ST_ENT_PASS,
        ST_EXT_PASS,
        ST_LOCK
    } state_t;

    typedef enum logic {
        SIDE_ENTRY,
        SIDE_EXIT
    } side_t;

    state_t             state_q, state_d;
    side_t              last_served_q, last_served_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic [TRY_W-1:0]   tries_q, tries_d;
    logic [TRY_W-1:0]   tries_inc;
    logic [CNT_W-1:0]   car_count_q, car_count_d;
    logic               ent_grant_q, ent_grant_d;
    logic               ext_grant_q, ext_grant_d;
    logic               gled_q, gled_d;
    logic               rled_q, rled_d;
    logic               full_q, full_d;
    logic               lockout_q, lockout_d;
    // Set once lane_busy has been seen high during a pass; the pass then
    // completes on the following low level (the fall).
    logic               seen_busy_q, seen_busy_d;

    logic               ent_elig;
    logic               ext_elig;
    logic               pass_is_entry;

`ifdef PARK_STATS_EN
    logic [15:0]        entries_q, entries_d;
    logic [15:0]        rejects_q, rejects_d;
`endif

    assign ent_elig      = ent_req && !full_q && !lane_busy;
    assign ext_elig      = ext_req && (car_count_q != CNT_ZERO) && !lane_busy;
    assign pass_is_entry = (state_q == ST_ENT_PASS);
    assign tries_inc     = tries_q + TRY_W'(1);

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        last_served_d = last_served_q;
        timer_d       = timer_q;
        tries_d       = tries_q;
        car_count_d   = car_count_q;
        ent_grant_d   = ent_grant_q;
        ext_grant_d   = ext_grant_q;
        lockout_d     = lockout_q;
        seen_busy_d   = seen_busy_q;
`ifdef PARK_STATS_EN
        entries_d     = entries_q;
        rejects_d     = rejects_q;
`endif

        case (state_q)
            ST_IDLE: begin
                // Entry wins unless exit is also eligible and entry was
                // the side served last.
                if (ent_elig && (!ext_elig || last_served_q == SIDE_EXIT)) begin
                    state_d = ST_AUTH;
                    timer_d = '0;
                end else if (ext_elig) begin
                    state_d     = ST_EXT_PASS;
                    timer_d     = '0;
                    ext_grant_d = 1'b1;
                    seen_busy_d = 1'b0;
                end
            end

            ST_AUTH: begin
                // pw_bad takes priority, so a simultaneous ok+bad is a reject.
                if (pw_bad) begin
                    tries_d = tries_inc;
                    timer_d = '0;
`ifdef PARK_STATS_EN
                    if (rejects_q != 16'hFFFF) begin
                        rejects_d = rejects_q + 16'd1;
                    end
`endif
                    if (tries_inc >= TRY_MAX) begin
                        state_d   = ST_LOCK;
                        lockout_d = 1'b1;
                    end
                end else if (pw_ok) begin
                    state_d     = ST_ENT_PASS;
                    ent_grant_d = 1'b1;
                    tries_d     = '0;
                    timer_d     = '0;
                    seen_busy_d = 1'b0;
                end else if (!ent_req || timer_q == TMO_LAST) begin
                    // Abandoned attempt: failures so far are remembered.
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end

            ST_ENT_PASS, ST_EXT_PASS: begin
                if (seen_busy_q) begin
                    if (!lane_busy) begin
                        state_d     = ST_IDLE;
                        ent_grant_d = 1'b0;
                        ext_grant_d = 1'b0;
                        seen_busy_d = 1'b0;
                        if (pass_is_entry) begin
                            last_served_d = SIDE_ENTRY;
                            if (car_count_q != CAP_C) begin
                                car_count_d = car_count_q + CNT_W'(1);
                            end
`ifdef PARK_STATS_EN
                            if (entries_q != 16'hFFFF) begin
                                entries_d = entries_q + 16'd1;
                            end
`endif
                        end else begin
                            last_served_d = SIDE_EXIT;
                            if (car_count_q != CNT_ZERO) begin
                                car_count_d = car_count_q - CNT_W'(1);
                            end
                        end
                    end
                end else if (lane_busy) begin
                    seen_busy_d = 1'b1;
                end else if (timer_q == TMO_LAST) begin
                    // Car never moved into the lane: close the barrier but
                    // still rotate priority so the other side gets a turn.
                    state_d       = ST_IDLE;
                    ent_grant_d   = 1'b0;
                    ext_grant_d   = 1'b0;
                    last_served_d = pass_is_entry ? SIDE_ENTRY : SIDE_EXIT;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end

            ST_LOCK: begin
                if (timer_q == LOCK_LAST) begin
                    state_d   = ST_IDLE;
                    lockout_d = 1'b0;
                    tries_d   = '0;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end

            default: begin
                state_d     = ST_IDLE;
                ent_grant_d = 1'b0;
                ext_grant_d = 1'b0;
                lockout_d   = 1'b0;
            end
        endcase

        gled_d = ent_grant_d | ext_grant_d;
        rled_d = !gled_d;
        full_d = (car_count_d == CAP_C);
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            last_served_q <= SIDE_EXIT;
            timer_q       <= '0;
            tries_q       <= '0;
            car_count_q   <= '0;
            ent_grant_q   <= 1'b0;
            ext_grant_q   <= 1'b0;
            gled_q        <= 1'b0;
            rled_q        <= 1'b1;
            full_q        <= 1'b0;
            lockout_q     <= 1'b0;
            seen_busy_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_served_q <= last_served_d;
            timer_q       <= timer_d;
            tries_q       <= tries_d;
            car_count_q   <= car_count_d;
            ent_grant_q   <= ent_grant_d;
            ext_grant_q   <= ext_grant_d;
            gled_q        <= gled_d;
            rled_q        <= rled_d;
            full_q        <= full_d;
            lockout_q     <= lockout_d;
            seen_busy_q   <= seen_busy_d;
        end
    end

`ifdef PARK_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            entries_q <= '0;
            rejects_q <= '0;
        end else begin
            entries_q <= entries_d;
            rejects_q <= rejects_d;
        end
    end

    assign tot_entries = entries_q;
    assign tot_rejects = rejects_q;
`endif

    assign ent_grant = ent_grant_q;
    assign ext_grant = ext_grant_q;
    assign gLED      = gled_q;
    assign rLED      = rled_q;
    assign car_count = car_count_q;
    assign full      = full_q;
    assign lockout   = lockout_q;

endmodule

// File: tb/tb_parking_lane_arbiter.sv
// ============================================================================
// tb_parking_lane_arbiter
//
// Directed bench for parking_lane_arbiter: a per-cycle vector table for the
// basic entry/exit/round-robin flow, followed by hand-written sequences for
// capacity, lockout, timeouts and asynchronous reset.
// ============================================================================
module tb_parking_lane_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ent_req, ext_req, pw_ok, pw_bad, lane_busy;
    logic       ent_grant, ext_grant, gLED, rLED;
    logic [3:0] car_count;
    logic       full, lockout;
`ifdef PARK_STATS_EN
    logic [15:0] tot_entries, tot_rejects;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    parking_lane_arbiter dut (
        .clk       (clk),
        .reset     (rst_n),
        .ent_req   (ent_req),
        .ext_req   (ext_req),
        .pw_ok     (pw_ok),
        .pw_bad    (pw_bad),
        .lane_busy (lane_busy),
        .ent_grant (ent_grant),
        .ext_grant (ext_grant),
        .gLED      (gLED),
        .rLED      (rLED),
        .car_count (car_count),
        .full      (full),
        .lockout   (lockout)
`ifdef PARK_STATS_EN
        ,
        .tot_entries (tot_entries),
        .tot_rejects (tot_rejects)
`endif
    );

    // One record = inputs held for one cycle + outputs expected after the edge.
    typedef struct {
        logic       ent, ext, ok, bad, lb;
        logic       eg, xg, g, r;
        logic [3:0] cnt;
        logic       fl, lk;
    } vec_t;

    function automatic vec_t mk(input logic ent, ext, ok, bad, lb,
                                input logic eg, xg, g, r,
                                input logic [3:0] cnt, input logic fl, lk);
        vec_t v;
        v.ent = ent; v.ext = ext; v.ok = ok; v.bad = bad; v.lb = lb;
        v.eg = eg; v.xg = xg; v.g = g; v.r = r;
        v.cnt = cnt; v.fl = fl; v.lk = lk;
        return v;
    endfunction

    function automatic logic [9:0] outs();
        return {ent_grant, ext_grant, gLED, rLED, car_count, full, lockout};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Drive inputs for one cycle, then sample 1 time unit after the edge.
    task automatic step(input logic e, input logic x, input logic ok,
                        input logic bad, input logic lb);
        ent_req = e; ext_req = x; pw_ok = ok; pw_bad = bad; lane_busy = lb;
        @(posedge clk);
        #1;
    endtask

    task automatic do_entry();
        step(1, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
    endtask

    vec_t vecs[18];

    initial begin
        //                ent ext ok bad lb  eg xg g r  cnt  fl lk
        vecs[0]  = mk(1, 0, 0, 0, 0,  0, 0, 0, 1, 4'd0, 0, 0); // IDLE->AUTH
        vecs[1]  = mk(1, 0, 1, 0, 0,  1, 0, 1, 0, 4'd0, 0, 0); // pw_ok -> grant
        vecs[2]  = mk(0, 0, 0, 0, 1,  1, 0, 1, 0, 4'd0, 0, 0); // car in lane
        vecs[3]  = mk(0, 0, 0, 0, 1,  1, 0, 1, 0, 4'd0, 0, 0);
        vecs[4]  = mk(0, 0, 0, 0, 1,  1, 0, 1, 0, 4'd0, 0, 0);
        vecs[5]  = mk(0, 0, 0, 0, 0,  0, 0, 0, 1, 4'd1, 0, 0); // fall: count 1
        vecs[6]  = mk(1, 0, 0, 0, 0,  0, 0, 0, 1, 4'd1, 0, 0);
        vecs[7]  = mk(1, 0, 1, 0, 0,  1, 0, 1, 0, 4'd1, 0, 0);
        vecs[8]  = mk(0, 0, 0, 0, 1,  1, 0, 1, 0, 4'd1, 0, 0);
        vecs[9]  = mk(0, 0, 0, 0, 0,  0, 0, 0, 1, 4'd2, 0, 0); // count 2, last=ENTRY
        vecs[10] = mk(1, 1, 0, 0, 0,  0, 1, 1, 0, 4'd2, 0, 0); // both -> exit first
        vecs[11] = mk(1, 1, 0, 0, 1,  0, 1, 1, 0, 4'd2, 0, 0);
        vecs[12] = mk(1, 1, 0, 0, 0,  0, 0, 0, 1, 4'd1, 0, 0); // exit done
        vecs[13] = mk(1, 1, 0, 0, 0,  0, 0, 0, 1, 4'd1, 0, 0); // both -> AUTH
        vecs[14] = mk(1, 1, 1, 0, 0,  1, 0, 1, 0, 4'd1, 0, 0);
        vecs[15] = mk(0, 1, 0, 0, 1,  1, 0, 1, 0, 4'd1, 0, 0);
        vecs[16] = mk(0, 0, 0, 0, 0,  0, 0, 0, 1, 4'd2, 0, 0);
        vecs[17] = mk(0, 0, 1, 0, 0,  0, 0, 0, 1, 4'd2, 0, 0); // stray pw_ok ignored

        ent_req = 0; ext_req = 0; pw_ok = 0; pw_bad = 0; lane_busy = 0;
        rst_n = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("reset_state", 32'(outs()), 32'(10'b0001_0000_00));
`ifdef PARK_STATS_EN
        chk("stats_reset", 32'({tot_entries, tot_rejects}), 32'd0);
`endif

        // ---------------- table-driven flow ----------------
        for (int i = 0; i < 18; i++) begin
            step(vecs[i].ent, vecs[i].ext, vecs[i].ok, vecs[i].bad, vecs[i].lb);
            chk($sformatf("vec%0d", i), 32'(outs()),
                32'({vecs[i].eg, vecs[i].xg, vecs[i].g, vecs[i].r,
                     vecs[i].cnt, vecs[i].fl, vecs[i].lk}));
        end

        // ---------------- fill to capacity ----------------
        do_entry();
        chk("cnt3", 32'({car_count, full}), 32'({4'd3, 1'b0}));
        do_entry();
        chk("cnt4_full", 32'({car_count, full}), 32'({4'd4, 1'b1}));
        for (int i = 0; i < 20; i++) begin
            step(1, 0, (i == 10), 0, 0);
            chk($sformatf("full_block%0d", i), 32'({ent_grant, rLED}), 32'({1'b0, 1'b1}));
        end
        step(0, 1, 0, 0, 0);
        chk("exit_from_full", 32'({ext_grant, gLED}), 32'({1'b1, 1'b1}));
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0);
        chk("cnt3_after_exit", 32'({car_count, full, ext_grant}), 32'({4'd3, 1'b0, 1'b0}));

        // ---------------- lockout ----------------
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 1, 0);
        chk("bad1_no_lock", 32'(lockout), 32'(0));
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 1, 0);
        chk("bad2_no_lock", 32'(lockout), 32'(0));
        step(1, 0, 0, 1, 0);
        chk("bad3_lock", 32'({lockout, rLED}), 32'({1'b1, 1'b1}));
        for (int i = 1; i < 16; i++) begin
            step(1, 0, (i == 5), 0, 0);
            chk($sformatf("lock_hold%0d", i), 32'({lockout, ent_grant}), 32'({1'b1, 1'b0}));
        end
        step(0, 0, 0, 0, 0);
        chk("lock_release", 32'(lockout), 32'(0));

        // Failures survive an abandoned attempt; ok+bad together is a reject.
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 1, 0);
        step(1, 0, 0, 1, 0);
        chk("retry_two_bad", 32'(lockout), 32'(0));
        step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 1, 1, 0);
        chk("retained_tries_lock", 32'({lockout, ent_grant}), 32'({1'b1, 1'b0}));
        for (int i = 1; i < 16; i++) step(0, 0, 0, 0, 0);
        chk("lock2_still", 32'(lockout), 32'(1));
        step(0, 0, 0, 0, 0);
        chk("lock2_release", 32'(lockout), 32'(0));

        // ---------------- AUTH timeout ----------------
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) step(1, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0);
        chk("auth_timeout_no_grant", 32'(ent_grant), 32'(0));
        step(1, 0, 1, 0, 0);
        chk("auth_again_grant", 32'(ent_grant), 32'(1));

        // ---------------- pass timeout (lane never busy) ----------------
        for (int i = 1; i < 8; i++) begin
            step(0, 0, 0, 0, 0);
            chk($sformatf("pass_hold%0d", i), 32'(ent_grant), 32'(1));
        end
        step(0, 0, 0, 0, 0);
        chk("pass_timeout", 32'({ent_grant, gLED, rLED, car_count}),
            32'({1'b0, 1'b0, 1'b1, 4'd3}));

        // ---------------- async reset mid-pass ----------------
        step(1, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0);
        step(0, 0, 0, 0, 1);
        chk("pre_reset_grant", 32'(ent_grant), 32'(1));
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset", 32'(outs()), 32'(10'b0001_0000_00));
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(0, 1, 0, 0, 0);
        chk("no_exit_when_empty", 32'({ext_grant, car_count}), 32'({1'b0, 4'd0}));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
